// File: rtl/acumulador_pontos_pkg.sv
// Shared definitions for the team score register: score limit, FSM states
// and the add/subtract operation encoding.
package acumulador_pontos_pkg;

    localparam int unsigned MAX_SCORE = 99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

endpackage

// File: rtl/conversor_bin_bcd.sv
// Combinational binary to two-digit BCD conversion for the 7-segment drivers.
// Valid for inputs 0..99.
module conversor_bin_bcd #(
    parameter int unsigned SCORE_W = 7
) (
    input  logic [SCORE_W-1:0] bin_i,
    output logic [3:0]         dezena_o,
    output logic [3:0]         unidade_o
);

    assign dezena_o  = 4'(bin_i / SCORE_W'(10));
    assign unidade_o = 4'(bin_i % SCORE_W'(10));

endmodule

// File: rtl/acumulador_pontos.sv
// Score register for one team: performs confirmed, guarded add/subtract
// requests of 1..3 points, keeps the score within 0..MAX_SCORE and exposes
// it as binary and registered BCD digits.
module acumulador_pontos #(
    parameter int unsigned SCORE_W   = 7,
    parameter int unsigned PTS_W     = 2,
    parameter int unsigned MAX_SCORE = acumulador_pontos_pkg::MAX_SCORE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               chavePN,
    input  logic [PTS_W-1:0]   pontos,
    input  logic               btn_confirm,
    input  logic               zerar,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         dezena,
    output logic [3:0]         unidade,
    output logic               erro,
    output logic               busy
);

    import acumulador_pontos_pkg::*;

    state_t             state_q;
    op_t                op_q;
    logic [PTS_W-1:0]   pts_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;
    logic               erro_q;
    logic               btn_q;
    logic               armed_q;
    logic               btn_edge;
    logic               chk_reject;
    logic [SCORE_W:0]   sum_w;
    logic [3:0]         dezena_q;
    logic [3:0]         unidade_q;
    logic [3:0]         dezena_c;
    logic [3:0]         unidade_c;

    // armed_q is low only in the first cycle after reset, so a button held
    // through reset release cannot be mistaken for a fresh press.
    assign btn_edge = btn_confirm & ~btn_q & armed_q;

    // Sum is one bit wider than the score so an overflowing add cannot wrap.
    assign sum_w = {1'b0, score_q} + (SCORE_W+1)'(pts_q);

    // Guard evaluation for the latched request and the resulting score.
    always_comb begin
        chk_reject = 1'b0;
        score_d    = score_q;
        if (op_q == OP_SUB) begin
            if (score_q < SCORE_W'(pts_q)) chk_reject = 1'b1;
            else                           score_d    = score_q - SCORE_W'(pts_q);
        end else begin
            if (sum_w > (SCORE_W+1)'(MAX_SCORE)) chk_reject = 1'b1;
            else                                 score_d    = sum_w[SCORE_W-1:0];
        end
    end

    // Request FSM: latch on a confirmed edge, apply once, wait for release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            pts_q   <= '0;
            score_q <= '0;
            erro_q  <= 1'b0;
            btn_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            btn_q   <= btn_confirm;
            armed_q <= 1'b1;
            if (zerar) begin
                score_q <= '0;
                erro_q  <= 1'b0;
                state_q <= btn_confirm ? ST_WAIT : ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (btn_edge && pontos != '0) begin
                            op_q    <= op_t'(chavePN);
                            pts_q   <= pontos;
                            state_q <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (chk_reject) begin
                            erro_q <= 1'b1;
                        end else begin
                            score_q <= score_d;
                            erro_q  <= 1'b0;
                        end
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (!btn_confirm) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    conversor_bin_bcd #(
        .SCORE_W (SCORE_W)
    ) u_bcd (
        .bin_i     (score_q),
        .dezena_o  (dezena_c),
        .unidade_o (unidade_c)
    );

    // BCD digits registered from the score, one cycle behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dezena_q  <= '0;
            unidade_q <= '0;
        end else begin
            dezena_q  <= dezena_c;
            unidade_q <= unidade_c;
        end
    end

    assign score   = score_q;
    assign dezena  = dezena_q;
    assign unidade = unidade_q;
    assign erro    = erro_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_acumulador_pontos.sv
// Self-checking bench for acumulador_pontos: a transaction-level score model
// checked every cycle, directed scenarios with literal expectations, and a
// randomized press/clear/reset phase.
module tb_acumulador_pontos;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       chavePN = 1'b0;
    logic [1:0] pontos = 2'd0;
    logic       btn_confirm = 1'b0;
    logic       zerar = 1'b0;
    logic [6:0] score;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic       erro;
    logic       busy;

    acumulador_pontos #(
        .SCORE_W   (7),
        .PTS_W     (2),
        .MAX_SCORE (99)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chavePN     (chavePN),
        .pontos      (pontos),
        .btn_confirm (btn_confirm),
        .zerar       (zerar),
        .score       (score),
        .dezena      (dezena),
        .unidade     (unidade),
        .erro        (erro),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: score as a plain integer; a pending request applied one clock
    // after the press, and a "held" flag meaning a press must be released.
    int  m_score = 0, m_erro = 0, m_dez = 0, m_uni = 0;
    int  m_pending = 0, m_held = 0, m_op = 0, m_pts = 0;
    int  m_prev_btn = 0, m_armed = 0, m_press = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_score = 0; m_erro = 0; m_dez = 0; m_uni = 0;
            m_pending = 0; m_held = 0; m_op = 0; m_pts = 0;
            m_prev_btn = 0; m_armed = 0;
        end else begin
            m_dez      = m_score / 10;
            m_uni      = m_score % 10;
            m_press    = (btn_confirm && !m_prev_btn && m_armed) ? 1 : 0;
            m_prev_btn = btn_confirm;
            m_armed    = 1;
            if (zerar) begin
                m_score   = 0;
                m_erro    = 0;
                m_pending = 0;
                m_held    = btn_confirm ? 1 : 0;
            end else if (m_pending != 0) begin
                if (m_op == 1) begin
                    if (m_pts <= m_score) begin m_score = m_score - m_pts; m_erro = 0; end
                    else m_erro = 1;
                end else begin
                    if (m_score + m_pts <= 99) begin m_score = m_score + m_pts; m_erro = 0; end
                    else m_erro = 1;
                end
                m_pending = 0;
                m_held    = 1;
            end else if (m_held != 0) begin
                if (!btn_confirm) m_held = 0;
            end else if (m_press != 0 && pontos != 2'd0) begin
                m_pending = 1;
                m_op      = chavePN;
                m_pts     = pontos;
            end
        end
    end

    // Per-cycle comparison against the model, just after each active edge.
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("score",   int'(score),   m_score);
            chk("dezena",  int'(dezena),  m_dez);
            chk("unidade", int'(unidade), m_uni);
            chk("erro",    int'(erro),    m_erro);
            chk("busy",    int'(busy),    (m_pending != 0 || m_held != 0) ? 1 : 0);
        end
    end

    // Hand-computed expectation checked against both the DUT and the model.
    task automatic lit(input string name, input int act, input int mdl, input int val);
        chk(name, act, val);
        chk({name, "_model"}, mdl, val);
    endtask

    task automatic press(input bit op, input int pts, input int hold, input int gap);
        @(negedge clk);
        chavePN     = op;
        pontos      = 2'(pts);
        btn_confirm = 1'b1;
        repeat (hold) @(negedge clk);
        btn_confirm = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic clear_score();
        @(negedge clk);
        zerar = 1'b1;
        @(negedge clk);
        zerar = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        lit("reset_score", int'(score), m_score, 0);
        lit("reset_busy",  int'(busy),  (m_pending != 0 || m_held != 0) ? 1 : 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three presses of +3.
        press(1'b0, 3, 2, 4); lit("add3_a", int'(score), m_score, 3);
        press(1'b0, 3, 2, 4); lit("add3_b", int'(score), m_score, 6);
        press(1'b0, 3, 2, 4); lit("add3_c", int'(score), m_score, 9);
        lit("add3_dez", int'(dezena),  m_dez,  0);
        lit("add3_uni", int'(unidade), m_uni,  9);
        lit("add3_err", int'(erro),    m_erro, 0);

        // Subtract underflow guard, then exact subtract to zero.
        clear_score();
        press(1'b0, 2, 2, 4); lit("sub_setup", int'(score), m_score, 2);
        press(1'b1, 3, 2, 4);
        lit("sub_rej_score", int'(score), m_score, 2);
        lit("sub_rej_err",   int'(erro),  m_erro,  1);
        press(1'b1, 2, 2, 4);
        lit("sub_eq_score", int'(score), m_score, 0);
        lit("sub_eq_err",   int'(erro),  m_erro,  0);

        // Overflow guard at the top of the range.
        clear_score();
        repeat (32) press(1'b0, 3, 1, 3);
        press(1'b0, 1, 1, 4);
        lit("top_setup", int'(score), m_score, 97);
        press(1'b0, 3, 2, 4);
        lit("ovf_score", int'(score), m_score, 97);
        lit("ovf_err",   int'(erro),  m_erro,  1);
        press(1'b0, 2, 2, 4);
        lit("max_score", int'(score),   m_score, 99);
        lit("max_dez",   int'(dezena),  m_dez,   9);
        lit("max_uni",   int'(unidade), m_uni,   9);
        lit("max_err",   int'(erro),    m_erro,  0);

        // Held button: one increment only, busy drops right after release.
        clear_score();
        @(negedge clk);
        chavePN = 1'b0; pontos = 2'd1; btn_confirm = 1'b1;
        repeat (5) @(negedge clk);
        lit("hold_busy", int'(busy), (m_pending != 0 || m_held != 0) ? 1 : 0, 1);
        pontos = 2'd3; chavePN = 1'b1;
        repeat (15) @(negedge clk);
        lit("hold_score",      int'(score), m_score, 1);
        lit("hold_busy_end",   int'(busy),  (m_pending != 0 || m_held != 0) ? 1 : 0, 1);
        btn_confirm = 1'b0;
        @(negedge clk);
        lit("hold_busy_rel",   int'(busy),  (m_pending != 0 || m_held != 0) ? 1 : 0, 0);
        repeat (3) @(negedge clk);
        lit("hold_score_rel",  int'(score), m_score, 1);

        // zerar coinciding with the CHECK cycle discards the request.
        clear_score();
        repeat (16) press(1'b0, 3, 1, 3);
        press(1'b0, 2, 1, 4);
        lit("z_setup", int'(score), m_score, 50);
        @(negedge clk);
        chavePN = 1'b0; pontos = 2'd2; btn_confirm = 1'b1;
        @(negedge clk);
        zerar = 1'b1;
        @(negedge clk);
        zerar = 1'b0;
        lit("z_busy_held", int'(busy), (m_pending != 0 || m_held != 0) ? 1 : 0, 1);
        btn_confirm = 1'b0;
        repeat (4) @(negedge clk);
        lit("z_score", int'(score),  m_score, 0);
        lit("z_err",   int'(erro),   m_erro,  0);
        lit("z_dez",   int'(dezena), m_dez,   0);

        // Reset during WAIT_REL with the button held through release.
        @(negedge clk);
        chavePN = 1'b0; pontos = 2'd1; btn_confirm = 1'b1;
        repeat (4) @(negedge clk);
        lit("r_pre", int'(score), m_score, 1);
        rst_n = 1'b0;
        #1;
        lit("r_async", int'(score), m_score, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        lit("r_held_score", int'(score), m_score, 0);
        lit("r_held_busy",  int'(busy),  (m_pending != 0 || m_held != 0) ? 1 : 0, 0);
        btn_confirm = 1'b0;
        repeat (2) @(negedge clk);
        press(1'b0, 1, 2, 4);
        lit("r_repress", int'(score), m_score, 1);

        // Randomized presses with in-flight input changes, clears and resets.
        for (int unsigned i = 0; i < 400; i++) begin
            int unsigned hold;
            int unsigned gap;
            int unsigned roll;
            hold = $urandom_range(1, 4);
            gap  = $urandom_range(0, 3);
            roll = $urandom_range(0, 99);
            @(negedge clk);
            chavePN     = ($urandom_range(0, 9) < 6) ? 1'b0 : 1'b1;
            pontos      = 2'($urandom_range(0, 3));
            btn_confirm = 1'b1;
            for (int unsigned h = 0; h < hold; h++) begin
                @(negedge clk);
                if ($urandom_range(0, 1) == 1) begin
                    chavePN = 1'($urandom_range(0, 1));
                    pontos  = 2'($urandom_range(0, 3));
                end
                zerar = (roll < 4 && h == 0) ? 1'b1 : 1'b0;
            end
            zerar       = 1'b0;
            btn_confirm = 1'b0;
            if (roll == 99) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            repeat (gap) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/acumulador_pontos.md
Name: acumulador_pontos

Overview:
Score register for one team on the basketball scoreboard. Accepts confirmed add or subtract requests of 1–3 points and updates a 7-bit score held within 0..MAX_SCORE. It rejects any request that would underflow or overflow, and exposes the score as binary and as two BCD digits for the 7-segment drivers. It is the consumer side of the subtraction-guard comparison: it performs the guarded operation and owns the state the guard inspects.

Parameters:
SCORE_W, 7, score width in bits
PTS_W, 2, point-value width (legal values 1..3)
MAX_SCORE, 99, highest displayable score

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
chavePN  in  1  operation select: 0 = add, 1 = subtract
pontos  in  PTS_W  point value of the request; 0 means no request
btn_confirm  in  1  confirm button, already debounced and synchronised, active-high level
zerar  in  1  synchronous score clear, active-high
score  out  SCORE_W  current score, binary
dezena  out  4  BCD tens digit of score
unidade  out  4  BCD units digit of score
erro  out  1  sticky flag: last request was rejected
busy  out  1  high while a request is in flight or the button is still held

Behaviour:
- One clock domain; only rst_n is asynchronous.
- Reset values: score=0, dezena=0, unidade=0, erro=0, busy=0, FSM=IDLE, btn_q=0.
- Edge detect:
  - btn_q is registered from btn_confirm.
  - edge = btn_confirm & ~btn_q.
- FSM states: IDLE, CHECK, WAIT_REL.
- IDLE:
  - On edge with pontos!=0: latch op_q=chavePN and pts_q=pontos, then go to CHECK.
  - On edge with pontos==0: ignore the edge and stay in IDLE.
- CHECK (exactly one cycle):
  - Subtract with score < pts_q: reject. Set erro=1; score unchanged.
  - Add with score + pts_q > MAX_SCORE: reject. Set erro=1; score unchanged. Compute the sum at SCORE_W+1 bits so it cannot wrap.
  - Otherwise accept. score <= score ± pts_q and erro <= 0.
  - Always go to WAIT_REL.
- WAIT_REL: stay until btn_confirm==0, then go to IDLE. A held button never repeats the operation.
- busy = (state != IDLE), decoded combinationally from the state register.
- Latency:
  - Edge detected in cycle N.
  - score valid after the clock edge ending cycle N+1.
  - dezena/unidade valid one cycle later, at N+2, because the BCD outputs are registered from score.
- Boundaries:
  - Subtract exactly equal to score yields 0 (accepted).
  - Add reaching exactly MAX_SCORE is accepted.
  - chavePN or pontos changing after the edge has no effect on the in-flight request, since the values are latched.
- zerar:
  - Highest priority; acts in any state.
  - Sets score=0 and erro=0, and forces the FSM to WAIT_REL if btn_confirm=1, else to IDLE.
  - A CHECK in the same cycle as zerar is discarded.
- rst_n asserted mid-operation clears everything immediately. After release, a still-held button does not trigger, because btn_q resets to 0 and the FSM needs a fresh edge from IDLE. Implementation must make btn_q track btn_confirm during the first post-reset cycle so a held button produces no edge.

Decomposition:
- Shared package:
  - MAX_SCORE
  - state encoding constants (ST_IDLE=2'd0, ST_CHECK=2'd1, ST_WAIT=2'd2)
  - operation encoding (OP_ADD=0, OP_SUB=1)
- One sub-module: conversor_bin_bcd. Purely combinational, SCORE_W binary in, two 4-bit BCD digits out, valid for inputs 0..99. The parent registers its outputs.

Test Plan:
- Reset, then add 3 three times (chavePN=0, pontos=3, one press each) -> score 3, 6, 9; dezena=0, unidade=9; erro=0.
- score=2, subtract 3 -> score stays 2, erro=1. Then subtract 2 -> score=0, erro=0.
- score=97, add 3 -> rejected, score 97, erro=1. Then add 2 -> score 99, dezena=9, unidade=9.
- Hold btn_confirm 20 cycles with add 1 -> score increments exactly once; busy high until the cycle after release.
- score=50, press add 2 and assert zerar in the CHECK cycle -> score=0, erro=0, no +2 applied.
- Assert rst_n low during WAIT_REL with the button held, release reset with the button still held -> score=0 and no increment until the button is released and pressed again.
